// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache refill controller.
// Contents: FSM state enum, line/word geometry constants, and helpers to
// line-align an address and to locate a word inside a cache line.
package cache_pkg;

  localparam int unsigned LINE_OFFSET_W = 6;  // byte offset inside a 64-byte line
  localparam int unsigned WORD_IDX_W    = 4;  // 16 words per line

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_REQ,
    ST_FILL,
    ST_RESP
  } state_e;

  // Clear the line-offset bits of an address (callers cast to their width).
  function automatic logic [63:0] line_align(input logic [63:0] addr);
    return {addr[63:LINE_OFFSET_W], LINE_OFFSET_W'(0)};
  endfunction

  // Word index within the line from the byte offset (byte-in-word bits dropped).
  function automatic logic [WORD_IDX_W-1:0] word_idx(input logic [LINE_OFFSET_W-1:0] off);
    return WORD_IDX_W'(off >> 2);
  endfunction

  // Bit position of word idx inside a line; word 0 sits at bit 0.
  function automatic int unsigned word_lsb(input logic [WORD_IDX_W-1:0] idx,
                                           input int unsigned word_w);
    return 32'(idx) * word_w;
  endfunction

endpackage

// File: rtl/refill_timeout_ctr.sv
// Memory-wait timeout counter.
// Ports: clk, reset (sync, active-high), clr_i (synchronous clear),
//        en_i (count one cycle), expire_o (registered: the current cycle is
//        the LIMIT-th counted cycle since the last clear).
module refill_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // Next count: clear wins, then increment, holding at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expire_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      expire_q <= (LIMIT <= 1);
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Request/response sequencer for a direct-mapped cache: probes the cache,
// refills a 512-bit line from main memory on a miss, returns the 32-bit word.
// Ports:
//   cpu_req_valid/cpu_req_ready/cpu_addr          CPU request (accepted in IDLE)
//   cpu_resp_valid/cpu_resp_data/cpu_resp_hit     one-cycle response
//   cache_lookup/cache_addr/cache_hit/cache_rdata cache probe
//   cache_fill/cache_fill_line                    line write
//   mem_req/mem_addr/mem_ack/mem_rdata            block read, level until ack
//   err                                           one-cycle memory-timeout pulse
// Optional build macro CACHE_REFILL_STATS_EN adds saturating hit_count,
// miss_count and timeout_count outputs.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_W      = 512,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_resp_valid,
  output logic [WORD_W-1:0] cpu_resp_data,
  output logic              cpu_resp_hit,
  output logic              cache_lookup,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  input  logic [WORD_W-1:0] cache_rdata,
  output logic              cache_fill,
  output logic [LINE_W-1:0] cache_fill_line,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              err
`ifdef CACHE_REFILL_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       timeout_count
`endif
);

  localparam int unsigned STAT_W = 32;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              hit_q, hit_d;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              lookup_q, lookup_d;
  logic              fill_q, fill_d;
  logic              mem_req_q, mem_req_d;
  logic              err_q, err_d;
  logic              expire;

  refill_timeout_ctr #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q == ST_RESP),
    .en_i     (state_q == ST_MEM_REQ),
    .expire_o (expire)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mem_addr_d   = mem_addr_q;
    line_d       = line_q;
    data_d       = data_q;
    hit_d        = hit_q;
    err_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req_valid) begin
          // Byte-in-word bits are dropped: reads are always word-aligned.
          addr_d     = cpu_addr & ~ADDR_W'(3);
          mem_addr_d = ADDR_W'(line_align(64'(cpu_addr)));
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (cache_hit) begin
          data_d  = cache_rdata;
          hit_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_MEM_REQ;
        end
      end
      ST_MEM_REQ: begin
        // An ack arriving on the expiry cycle still completes the refill.
        if (mem_ack) begin
          line_d  = mem_rdata;
          state_d = ST_FILL;
        end else if (expire) begin
          data_d  = '0;
          hit_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_FILL: begin
        data_d  = WORD_W'(line_q >> word_lsb(word_idx(addr_q[LINE_OFFSET_W-1:0]), WORD_W));
        hit_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they are registered.
    ready_d      = (state_d == ST_IDLE);
    lookup_d     = (state_d == ST_LOOKUP);
    mem_req_d    = (state_d == ST_MEM_REQ);
    fill_d       = (state_d == ST_FILL);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      line_q       <= '0;
      data_q       <= '0;
      hit_q        <= 1'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      lookup_q     <= 1'b0;
      fill_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mem_addr_q   <= mem_addr_d;
      line_q       <= line_d;
      data_q       <= data_d;
      hit_q        <= hit_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      lookup_q     <= lookup_d;
      fill_q       <= fill_d;
      mem_req_q    <= mem_req_d;
      err_q        <= err_d;
    end
  end

  assign cpu_req_ready   = ready_q;
  assign cpu_resp_valid  = resp_valid_q;
  assign cpu_resp_data   = data_q;
  assign cpu_resp_hit    = hit_q;
  assign cache_lookup    = lookup_q;
  assign cache_addr      = addr_q;
  assign cache_fill      = fill_q;
  assign cache_fill_line = line_q;
  assign mem_req         = mem_req_q;
  assign mem_addr        = mem_addr_q;
  assign err             = err_q;

`ifdef CACHE_REFILL_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [STAT_W-1:0] to_cnt_q, to_cnt_d;

  // Saturating event counters; a timed-out access also counts as a miss.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    to_cnt_d   = to_cnt_q;
    if ((state_q == ST_LOOKUP) && cache_hit && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + STAT_W'(1);
    end
    if ((state_q == ST_LOOKUP) && !cache_hit && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + STAT_W'(1);
    end
    if (err_d && (to_cnt_q != '1)) begin
      to_cnt_d = to_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;
  assign timeout_count = to_cnt_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: the driver pushes expected
// responses/fills, a negedge monitor pops and compares them.
module tb_cache_refill_ctrl;

  localparam int unsigned TB_TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req_valid;
  logic         cpu_req_ready;
  logic [31:0]  cpu_addr;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_data;
  logic         cpu_resp_hit;
  logic         cache_lookup;
  logic [31:0]  cache_addr;
  logic         cache_hit;
  logic [31:0]  cache_rdata;
  logic         cache_fill;
  logic [511:0] cache_fill_line;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [511:0] mem_rdata;
  logic         err;
`ifdef CACHE_REFILL_STATS_EN
  logic [31:0]  hit_count, miss_count, timeout_count;
`endif

  cache_refill_ctrl #(
    .ADDR_W      (32),
    .LINE_W      (512),
    .WORD_W      (32),
    .MEM_TIMEOUT (TB_TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_ready   (cpu_req_ready),
    .cpu_addr        (cpu_addr),
    .cpu_resp_valid  (cpu_resp_valid),
    .cpu_resp_data   (cpu_resp_data),
    .cpu_resp_hit    (cpu_resp_hit),
    .cache_lookup    (cache_lookup),
    .cache_addr      (cache_addr),
    .cache_hit       (cache_hit),
    .cache_rdata     (cache_rdata),
    .cache_fill      (cache_fill),
    .cache_fill_line (cache_fill_line),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .err             (err)
`ifdef CACHE_REFILL_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count),
    .timeout_count   (timeout_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        hit;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t         resp_q[$];
  logic [511:0] fill_q[$];
  exp_t         e;
  logic [511:0] fl;

  int n_checks = 0;
  int n_pass   = 0;

  logic        allow_mem      = 1'b0;
  logic [31:0] exp_mem_addr   = '0;
  logic [31:0] exp_cache_addr = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [511:0] mk_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  // Monitor: compare whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          e = resp_q.pop_front();
          chk("resp_data", cpu_resp_data, e.data);
          chk("resp_hit", cpu_resp_hit, e.hit);
          chk("resp_err", err, e.err);
          chk("resp_cycle", cyc, e.cyc);
        end
      end else if (err) begin
        chk("err_without_resp", 1, 0);
      end
      if (cache_fill) begin
        if (fill_q.size() == 0) chk("unexpected_fill", 1, 0);
        else begin
          fl = fill_q.pop_front();
          chk("fill_line", cache_fill_line, fl);
        end
      end
      if (mem_req) begin
        if (!allow_mem) chk("unexpected_mem_req", 1, 0);
        else chk("mem_addr", mem_addr, exp_mem_addr);
      end
      if (cache_lookup) chk("cache_addr", cache_addr, exp_cache_addr);
    end
  end

  // kind: 0 = hit, 1 = miss with ack on the ack_k-th MEM_REQ cycle, 2 = timeout.
  task automatic run_req(input logic [31:0] addr, input int kind, input int ack_k,
                         input logic [31:0] hit_word, input logic [511:0] line,
                         input logic [31:0] exp_word, input logic [31:0] exp_maddr);
    int acc;
    int rc;
    cpu_req_valid  = 1'b1;
    cpu_addr       = addr;
    exp_cache_addr = addr;
    exp_mem_addr   = exp_maddr;
    allow_mem      = (kind != 0);
    acc            = cyc;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    cpu_addr      = 32'hFFFF_FFFC;
    cache_hit     = (kind == 0);
    cache_rdata   = (kind == 0) ? hit_word : 32'hBAD0_BAD0;
    chk("ready_busy", cpu_req_ready, 0);
    if (kind == 0) begin
      rc = acc + 2;
      resp_q.push_back('{data: hit_word, hit: 1'b1, err: 1'b0, cyc: rc});
    end else if (kind == 1) begin
      rc = acc + ack_k + 3;
      resp_q.push_back('{data: exp_word, hit: 1'b0, err: 1'b0, cyc: rc});
      fill_q.push_back(line);
    end else begin
      rc = acc + int'(TB_TO) + 2;
      resp_q.push_back('{data: 32'h0, hit: 1'b0, err: 1'b1, cyc: rc});
    end
    @(posedge clk); #1;
    cache_hit   = 1'b0;
    cache_rdata = $urandom();
    if (kind == 1) begin
      repeat (ack_k - 1) begin @(posedge clk); #1; end
      mem_ack   = 1'b1;
      mem_rdata = line;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = mk_line($urandom());
    end
    while (cyc < rc + 1) begin @(posedge clk); #1; end
    allow_mem = 1'b0;
    chk("ready_idle", cpu_req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_addr      = '0;
    cache_hit     = 1'b0;
    cache_rdata   = '0;
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cpu_req_ready, 1);
    chk("rst_resp_valid", cpu_resp_valid, 0);
    chk("rst_resp_data", cpu_resp_data, 0);
    chk("rst_lookup", cache_lookup, 0);
    chk("rst_fill", cache_fill, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_err", err, 0);
    chk("rst_cache_addr", cache_addr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fill_line", cache_fill_line, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset while waiting on memory: access aborted, late ack ignored.
    cpu_req_valid  = 1'b1;
    cpu_addr       = 32'h0000_4040;
    exp_cache_addr = 32'h0000_4040;
    exp_mem_addr   = 32'h0000_4040;
    allow_mem      = 1'b1;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    cache_hit     = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_mem_req_high", mem_req, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    allow_mem = 1'b0;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_ready", cpu_req_ready, 1);
    mem_ack   = 1'b1;
    mem_rdata = mk_line(32'h7700_0000);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_still_idle", cpu_req_ready, 1);

    // Hit at 0x100.
    run_req(32'h0000_0100, 0, 0, 32'hDEAD_BEEF, '0, '0, '0);
    // Miss at 0x1234, ack 5 cycles after mem_req rises; word 13 = 0x100D.
    run_req(32'h0000_1234, 1, 6, '0, mk_line(32'h0000_1000), 32'h0000_100D, 32'h0000_1200);
    // No ack: timeout after TB_TO MEM_REQ cycles, no fill.
    run_req(32'h0000_3004, 2, 0, '0, '0, '0, 32'h0000_3000);
    // Ack on the expiry cycle wins: word 2 of the line.
    run_req(32'h0000_2008, 1, int'(TB_TO), '0, mk_line(32'hA500_0000), 32'hA500_0002, 32'h0000_2000);

    // Back-to-back hits with the request held high across RESP.
    begin
      int acc;
      cpu_req_valid  = 1'b1;
      cpu_addr       = 32'h0000_0300;
      exp_cache_addr = 32'h0000_0300;
      acc            = cyc;
      @(posedge clk); #1;
      cache_hit   = 1'b1;
      cache_rdata = 32'hCAFE_F00D;
      cpu_addr    = 32'h0000_0304;
      resp_q.push_back('{data: 32'hCAFE_F00D, hit: 1'b1, err: 1'b0, cyc: acc + 2});
      @(posedge clk); #1;
      cache_hit   = 1'b0;
      cache_rdata = $urandom();
      @(posedge clk); #1;
      exp_cache_addr = 32'h0000_0304;
      chk("b2b_ready", cpu_req_ready, 1);
      @(posedge clk); #1;
      cpu_req_valid = 1'b0;
      cache_hit     = 1'b1;
      cache_rdata   = 32'h0BAD_F00D;
      resp_q.push_back('{data: 32'h0BAD_F00D, hit: 1'b1, err: 1'b0, cyc: acc + 5});
      @(posedge clk); #1;
      cache_hit = 1'b0;
      while (cyc < acc + 7) begin @(posedge clk); #1; end
    end

    chk("resp_queue_drained", 32'(resp_q.size()), 0);
    chk("fill_queue_drained", 32'(fill_q.size()), 0);
`ifdef CACHE_REFILL_STATS_EN
    chk("hit_count", hit_count, 3);
    chk("miss_count", miss_count, 3);
    chk("timeout_count", timeout_count, 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Sequencing controller for the direct-mapped cache datapath. It accepts one CPU read request at a time and probes the cache memory. On a miss it issues a block read to main memory, fills the 512-bit line into the cache, and returns the requested 32-bit word. It replaces the free-running always-read wiring with a proper request/response handshake and a memory timeout.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 512, cache line width in bits (16 words)
WORD_W, 32, CPU word width
MEM_TIMEOUT, 255, max cycles in MEM_REQ waiting for mem_ack before error (≥1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
cpu_req_valid  in  1  CPU read request
cpu_req_ready  out  1  controller can accept request (IDLE only)
cpu_addr  in  ADDR_W  request byte address, sampled on accept
cpu_resp_valid  out  1  one-cycle response pulse
cpu_resp_data  out  WORD_W  returned word
cpu_resp_hit  out  1  1 = served from cache, 0 = refill or error
cache_lookup  out  1  probe strobe to cache memory
cache_addr  out  ADDR_W  latched request address
cache_hit  in  1  cache tag-match result, valid during lookup cycle
cache_rdata  in  WORD_W  cache word, valid during lookup cycle
cache_fill  out  1  one-cycle line write strobe
cache_fill_line  out  LINE_W  line to write
mem_req  out  1  block read request, level, held until ack
mem_addr  out  ADDR_W  line-aligned address (low 6 bits zero)
mem_ack  in  1  memory line valid this cycle
mem_rdata  in  LINE_W  memory line
err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset: state IDLE; cpu_req_ready=1; all strobes, cpu_resp_*, mem_req and err are 0; cache_addr, mem_addr and cache_fill_line are 0; timeout counter is 0. Reset mid-operation aborts the access on the next edge. No response is issued for the aborted access.
- States: IDLE, LOOKUP, MEM_REQ, FILL, RESP.
- IDLE: cpu_req_ready=1. If cpu_req_valid=1, latch cpu_addr and go to LOOKUP.
- LOOKUP (1 cycle): cache_lookup=1; sample cache_hit and cache_rdata.
  - Hit: capture the word and go to RESP with hit=1.
  - Miss: go to MEM_REQ.
- MEM_REQ: mem_req=1, mem_addr={addr[ADDR_W-1:6],6'b0}; the timeout counter increments each cycle.
  - mem_ack=1: capture mem_rdata and go to FILL.
  - Counter reaches MEM_TIMEOUT without ack: pulse err and go to RESP with data 0 and hit=0. No fill is performed.
  - mem_ack on the timeout cycle: the ack wins and no error is raised.
- FILL (1 cycle): cache_fill=1 with cache_fill_line = captured line. The response word is line[idx*32 +: 32], where idx=addr[5:2]; word 0 occupies bits [31:0]. Then go to RESP with hit=0.
- RESP (1 cycle): cpu_resp_valid=1, then return to IDLE. The timeout counter clears.
- Latency, with accept at cycle 0:
  - Hit: response at cycle 2.
  - Miss: mem_req from cycle 2; ack at cycle N gives FILL at N+1 and response at N+2.
- cpu_addr changes after accept are ignored. mem_ack outside MEM_REQ is ignored. cpu_addr[1:0] is ignored (word-aligned reads).
- cpu_req_ready=0 in all states except IDLE. Back-to-back: a request held high is accepted in the IDLE cycle after RESP.

Optional Feature:
CACHE_REFILL_STATS_EN
- Defined: adds outputs hit_count, miss_count and timeout_count (32 bits each, saturating).
  - hit_count increments on a LOOKUP hit.
  - miss_count increments on a LOOKUP miss.
  - timeout_count increments on an err pulse.
  - All three clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cache_pkg: state enum, LINE_OFFSET_W=6, WORD_IDX_W=4, line-align and word-select helper functions.
- One natural sub-module, refill_timeout_ctr: counter with clear/enable and an expire flag at MEM_TIMEOUT.

Test Plan:
- Hit: cache_hit=1, cache_rdata=0xDEADBEEF, addr 0x100 -> resp_valid at cycle 2, data 0xDEADBEEF, hit=1, mem_req never high.
- Miss refill: addr 0x1234, mem_ack 5 cycles after mem_req with word k = 0x1000+k -> mem_addr 0x1200; one cache_fill with that line; resp data 0x100D (idx 13), hit=0.
- Timeout: MEM_TIMEOUT=4, no ack -> err pulse after 4 MEM_REQ cycles; resp data 0, hit=0; no cache_fill.
- Ack on timeout cycle: MEM_TIMEOUT=4, mem_ack on 4th cycle -> no err, fill occurs, normal response.
- Reset during MEM_REQ -> next cycle mem_req=0, IDLE, cpu_req_ready=1; a late mem_ack is ignored and produces no response.
- Stats (macro on): 3 hits, 2 misses, 1 timeout -> hit_count=3, miss_count=3 (timeout access counted as a miss), timeout_count=1.
